// File: rtl/iir_pkg.sv
// Shared types and helpers for the time-shared first-order IIR filter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package iir_pkg;

    localparam int IIR_NUM_CH = 4;
    localparam int IIR_DATA_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_WB   = 2'd2
    } iir_state_e;

    // y_new = low half of the product plus x, wrapping modulo 2^DATA_W.
    function automatic logic [IIR_DATA_W-1:0] wrap_add(
        input logic [2*IIR_DATA_W-1:0] prod,
        input logic [IIR_DATA_W-1:0]   x
    );
        return prod[IIR_DATA_W-1:0] + x;
    endfunction

endpackage

// File: rtl/bwsm.sv
// Signed W x W Baugh-Wooley multiplier producing the full 2W-bit product.
// Latency: combinational.
// Backpressure: none.
module bwsm #(
    parameter int W = 4
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);

    // Sum partial products; cross terms with exactly one sign bit are inverted
    // and the correction constant 2^W + 2^(2W-1) restores the signed result.
    always_comb begin
        logic [2*W-1:0] acc;
        logic [2*W-1:0] term;
        logic           pp;
        acc  = '0;
        term = '0;
        pp   = 1'b0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                pp = a_i[j] & b_i[i];
                if ((i == W - 1) != (j == W - 1)) begin
                    pp = ~pp;
                end
                term        = '0;
                term[i + j] = pp;
                acc         = acc + term;
            end
        end
        term          = '0;
        term[W]       = 1'b1;
        term[2*W - 1] = 1'b1;
        acc           = acc + term;
        p_o           = acc;
    end

endmodule

// File: rtl/iir_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module iir_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   idx_o,
    output logic              vld_o
);

    // Scan channels starting at the pointer; the index wraps naturally in CH_W bits.
    always_comb begin
        logic [CH_W-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = ptr_i + CH_W'(k);
            if (!vld_o && req_i[cand]) begin
                vld_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iir_channel_scheduler.sv
// Time-shares one y = a*y_prev + x datapath across NUM_CH channels, round-robin.
// Latency: accept at T, tagged result at T+2; one sample per 3 cycles.
// Backpressure: req_valid held until a 1-cycle one-hot req_ready pulse in IDLE.
module iir_channel_scheduler
    import iir_pkg::*;
#(
    parameter int NUM_CH = IIR_NUM_CH,
    parameter int DATA_W = IIR_DATA_W,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [DATA_W-1:0]        cfg_coef,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH*DATA_W-1:0] req_x,
    output logic [NUM_CH-1:0]        req_ready,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic [DATA_W-1:0]        out_y
);

    iir_state_e          state_q, state_d;
    logic [CH_W-1:0]     rr_q;
    logic [CH_W-1:0]     ch_q;
    logic [DATA_W-1:0]   x_q, a_q, y_q;
    logic [2*DATA_W-1:0] p_q;
    logic [DATA_W-1:0]   coef_q [NUM_CH];
    logic [DATA_W-1:0]   st_q   [NUM_CH];

    logic [NUM_CH-1:0]   gnt;
    logic [CH_W-1:0]     gnt_idx;
    logic                gnt_vld;
    logic                grant_fire;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   y_new;

    iir_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    // The single shared multiplier always sees the latched sample's operands.
    bwsm #(.W(DATA_W)) u_mul (
        .a_i (a_q),
        .b_i (y_q),
        .p_o (prod)
    );

    assign grant_fire = (state_q == ST_IDLE) && gnt_vld;
    assign y_new      = wrap_add(p_q, x_q);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs; everything is forced quiet while reset is high.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        out_valid = 1'b0;
        out_ch    = '0;
        out_y     = '0;
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        req_ready = gnt;
                        state_d   = ST_MULT;
                    end
                end
                ST_MULT: state_d = ST_WB;
                ST_WB: begin
                    out_valid = 1'b1;
                    out_ch    = ch_q;
                    out_y     = y_new;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Latch the granted sample with its coef/state snapshot, then register the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
            ch_q <= '0;
            x_q  <= '0;
            a_q  <= '0;
            y_q  <= '0;
            p_q  <= '0;
        end else begin
            if (grant_fire) begin
                ch_q <= gnt_idx;
                x_q  <= req_x[gnt_idx*DATA_W +: DATA_W];
                a_q  <= coef_q[gnt_idx];
                y_q  <= st_q[gnt_idx];
                rr_q <= gnt_idx + CH_W'(1);
            end
            if (state_q == ST_MULT) begin
                p_q <= prod;
            end
        end
    end

    // Per-channel storage: writeback first, a config write later in the block wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                coef_q[i] <= '0;
                st_q[i]   <= '0;
            end
        end else begin
            if (state_q == ST_WB) begin
                st_q[ch_q] <= y_new;
            end
            if (cfg_we) begin
                coef_q[cfg_ch] <= cfg_coef;
                st_q[cfg_ch]   <= '0;
            end
        end
    end

endmodule
